// File: rtl/regfile_write_port.sv
// 32-entry register file write side: one-hot decoded write, registered per-register outputs,
// write-event one-hot and commit counter. Define XZR_HARDWIRE_EN to hardwire R31 to zero.
module regfile_write_port #(
    parameter int N = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         write_en,
    input  logic [4:0]   write_addr,
    input  logic [N-1:0] write_data,
    output logic [N-1:0] R00,
    output logic [N-1:0] R01,
    output logic [N-1:0] R02,
    output logic [N-1:0] R03,
    output logic [N-1:0] R04,
    output logic [N-1:0] R05,
    output logic [N-1:0] R06,
    output logic [N-1:0] R07,
    output logic [N-1:0] R08,
    output logic [N-1:0] R09,
    output logic [N-1:0] R10,
    output logic [N-1:0] R11,
    output logic [N-1:0] R12,
    output logic [N-1:0] R13,
    output logic [N-1:0] R14,
    output logic [N-1:0] R15,
    output logic [N-1:0] R16,
    output logic [N-1:0] R17,
    output logic [N-1:0] R18,
    output logic [N-1:0] R19,
    output logic [N-1:0] R20,
    output logic [N-1:0] R21,
    output logic [N-1:0] R22,
    output logic [N-1:0] R23,
    output logic [N-1:0] R24,
    output logic [N-1:0] R25,
    output logic [N-1:0] R26,
    output logic [N-1:0] R27,
    output logic [N-1:0] R28,
    output logic [N-1:0] R29,
    output logic [N-1:0] R30,
    output logic [N-1:0] R31,
    output logic [31:0]  wr_onehot,
    output logic [15:0]  wr_count
);

    logic [N-1:0] regs_q [31];
    logic [31:0]  onehot_d;
    logic [31:0]  onehot_q;
    logic [15:0]  count_d;
    logic [15:0]  count_q;
    logic         commit;

    // Gated 5-to-32 decode; a write to a hardwired R31 decodes to nothing and is not counted.
    always_comb begin
        onehot_d = '0;
        if (write_en) begin
            onehot_d = 32'd1 << write_addr;
        end
`ifdef XZR_HARDWIRE_EN
        onehot_d[31] = 1'b0;
`endif
    end

    assign commit  = |onehot_d;
    assign count_d = commit ? count_q + 16'd1 : count_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int k = 0; k < 31; k++) begin
                regs_q[k] <= '0;
            end
            onehot_q <= '0;
            count_q  <= '0;
        end else begin
            for (int k = 0; k < 31; k++) begin
                if (onehot_d[k]) begin
                    regs_q[k] <= write_data;
                end
            end
            onehot_q <= onehot_d;
            count_q  <= count_d;
        end
    end

`ifdef XZR_HARDWIRE_EN
    assign R31 = '0;
`else
    logic [N-1:0] r31_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r31_q <= '0;
        end else if (onehot_d[31]) begin
            r31_q <= write_data;
        end
    end

    assign R31 = r31_q;
`endif

    assign R00 = regs_q[0];
    assign R01 = regs_q[1];
    assign R02 = regs_q[2];
    assign R03 = regs_q[3];
    assign R04 = regs_q[4];
    assign R05 = regs_q[5];
    assign R06 = regs_q[6];
    assign R07 = regs_q[7];
    assign R08 = regs_q[8];
    assign R09 = regs_q[9];
    assign R10 = regs_q[10];
    assign R11 = regs_q[11];
    assign R12 = regs_q[12];
    assign R13 = regs_q[13];
    assign R14 = regs_q[14];
    assign R15 = regs_q[15];
    assign R16 = regs_q[16];
    assign R17 = regs_q[17];
    assign R18 = regs_q[18];
    assign R19 = regs_q[19];
    assign R20 = regs_q[20];
    assign R21 = regs_q[21];
    assign R22 = regs_q[22];
    assign R23 = regs_q[23];
    assign R24 = regs_q[24];
    assign R25 = regs_q[25];
    assign R26 = regs_q[26];
    assign R27 = regs_q[27];
    assign R28 = regs_q[28];
    assign R29 = regs_q[29];
    assign R30 = regs_q[30];

    assign wr_onehot = onehot_q;
    assign wr_count  = count_q;

endmodule

// File: doc/regfile_write_port.md
REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

Interface
REQ-001 Parameter: N, default 64, data width of each register.
REQ-002 Port: clock  input  1  rising-edge clock, single clock domain.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: clear  input  1  synchronous clear of all registers, same effect as reset.
REQ-005 Port: write_en  input  1  write strobe, sampled on rising clock.
REQ-006 Port: write_addr  input  5  destination register index 0-31.
REQ-007 Port: write_data  input  N  value to store.
REQ-008 Port: R00..R31  output  N each  current register contents, 32 separate buses, index k on R<kk>, fed directly to the read-select muxes.
REQ-009 Port: wr_onehot  output  32  registered one-hot copy of the last accepted write address, all-zero if the last cycle committed no write.
REQ-010 Port: wr_count  output  16  count of writes committed since reset/clear.

Function
REQ-011 The 5-to-32 decode of write_addr, gated by write_en, SHALL select exactly one register; the others hold.
REQ-012 Write latency: data sampled at edge t SHALL appear on R<addr> immediately after edge t; there is no same-cycle bypass to the outputs.
REQ-013 R00..R31 SHALL be registered outputs only; no combinational path from write_* to R*.
REQ-014 wr_onehot SHALL be 1<<write_addr after an edge that committed a write, otherwise 32'h0, updated every edge.
REQ-015 wr_count SHALL increment by 1 per committed write, wrap from 16'hFFFF to 16'h0000, and never increment on ignored writes (REQ-021).
REQ-016 clear=1 SHALL zero all R*, wr_onehot and wr_count at the edge; clear wins over a simultaneous write, which is dropped and not counted.
REQ-017 write_en=0 SHALL leave all R*, wr_count unchanged regardless of write_addr/write_data.
REQ-018 Back-to-back writes to the same address SHALL leave the last value; each is counted.
REQ-019 write_data SHALL be stored unmodified at full N bits; no sign extension or truncation.

Reset
REQ-020 reset=1 at a rising edge SHALL force R00..R31=0, wr_onehot=0, wr_count=0; reset overrides clear and write_en; a write asserted in the reset cycle SHALL be lost, and operation SHALL resume on the first edge with reset=0.

Configuration
REQ-021 Macro XZR_HARDWIRE_EN: when defined, R31 SHALL be constant zero, writes to address 31 SHALL be ignored (no R31 change, wr_onehot=0, wr_count unchanged); when undefined, R31 SHALL be an ordinary writable register like R00..R30.

Verification
REQ-022 Reset: assert reset 2 cycles with write_en=1, addr=5, data=0xDEAD -> all R*=0, wr_onehot=0, wr_count=0.
REQ-023 Write walk: write k to address k for k=0..31 -> R<kk>=k for k<31; R31=31 without XZR_HARDWIRE_EN (wr_count=32) or R31=0 with it (wr_count=31, wr_onehot=0 after last write).
REQ-024 Hold: write_en=0, addr=3, data=0xFFFF for 10 cycles after R03=0x1234 -> R03 stays 0x1234, wr_count unchanged.
REQ-025 Simultaneous clear+write: R07=0x55, then clear=1, write_en=1, addr=7, data=0xAA -> R07=0, wr_count=0, wr_onehot=0.
REQ-026 Wrap: 65536 writes to address 2 -> wr_count=0, R02=last data, wr_onehot=32'h4.
REQ-027 Width: N=64, write 0xFFFF_FFFF_FFFF_FFFF to address 30 -> R30 equal all-ones, R29 and R31 unchanged.
